// File: rtl/unidad_control.sv
// Hardwired control unit for the UnidadDatos datapath: sequences one 8-bit
// register-transfer instruction into 1-3 single-bus micro-steps.
// Optional macro UC_RETIRE_CNT_EN adds a 16-bit retired-instruction counter.
module unidad_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] instr,
    output logic       in_ready,
    output logic       done,
    output logic       err,
    output logic       Ra,
    output logic       Rb,
    output logic       Rc,
    output logic       Rac,
    output logic       Wa,
    output logic       Wb,
    output logic       Wc,
    output logic       Wac,
    output logic       Wt,
    output logic       S,
    output logic       R
`ifdef UC_RETIRE_CNT_EN
    ,
    output logic [15:0] retired
`endif
);

    localparam int unsigned N_STEP_MAX = 3;
    // One state per micro-step kind plus IDLE.
    localparam int unsigned ST_W       = $clog2(N_STEP_MAX + 1);
    localparam int unsigned STRB_W     = 11;

    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b11;
    localparam logic [1:0] REG_AC = 2'b11;

    // Strobe word layout: {Ra, Rb, Rc, Rac, Wa, Wb, Wc, Wac, Wt, S, R}
    localparam logic [STRB_W-1:0] STB_RA  = 11'h400;
    localparam logic [STRB_W-1:0] STB_WA  = 11'h040;
    localparam logic [STRB_W-1:0] STB_WAC = 11'h008;
    localparam logic [STRB_W-1:0] STB_WT  = 11'h004;
    localparam logic [STRB_W-1:0] STB_S   = 11'h002;
    localparam logic [STRB_W-1:0] STB_R   = 11'h001;

    typedef enum logic [ST_W-1:0] {IDLE, CARGA_T, OPERA, GUARDA} state_t;

    state_t              state;
    state_t              first_step;
    state_t              next_step;
    logic [1:0]          op_q, x_q, y_q, z_q;
    logic [STRB_W-1:0]   strb;

    function automatic logic [STRB_W-1:0] rd_sel(input logic [1:0] c);
        return STB_RA >> c;
    endfunction

    function automatic logic [STRB_W-1:0] wr_sel(input logic [1:0] c);
        return STB_WA >> c;
    endfunction

    // Strobes for a given micro-step; exactly one reader at most by construction.
    function automatic logic [STRB_W-1:0] decode(input state_t st, input logic [1:0] op,
                                                 input logic [1:0] x, input logic [1:0] y,
                                                 input logic [1:0] z);
        logic [STRB_W-1:0] s;
        s = '0;
        case (st)
            CARGA_T: s = rd_sel(y) | STB_WT;
            OPERA: begin
                if (op == OP_CLR) s = STB_WAC;
                else              s = rd_sel(x) | STB_WAC | ((op == OP_ADD) ? STB_S : STB_R);
            end
            GUARDA: begin
                if (op == OP_MOV) s = (z == REG_AC) ? '0 : (rd_sel(x) | wr_sel(z));
                else              s = rd_sel(REG_AC) | wr_sel(z);
            end
            default: s = '0;
        endcase
        return s;
    endfunction

    always_comb begin
        first_step = CARGA_T;
        if (instr[7:6] == OP_MOV)      first_step = GUARDA;
        else if (instr[7:6] == OP_CLR) first_step = OPERA;

        next_step = IDLE;
        case (state)
            CARGA_T: next_step = OPERA;
            OPERA:   next_step = (z_q == REG_AC) ? IDLE : GUARDA;
            default: next_step = IDLE;
        endcase
    end

    assign {Ra, Rb, Rc, Rac, Wa, Wb, Wc, Wac, Wt, S, R} = strb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            strb     <= '0;
            in_ready <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef UC_RETIRE_CNT_EN
            retired  <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state == IDLE) begin
                if (in_ready && in_valid) begin
                    op_q     <= instr[7:6];
                    x_q      <= instr[5:4];
                    y_q      <= instr[3:2];
                    z_q      <= instr[1:0];
                    state    <= first_step;
                    strb     <= decode(first_step, instr[7:6], instr[5:4], instr[3:2], instr[1:0]);
                    in_ready <= 1'b0;
                end else begin
                    in_ready <= 1'b1;
                end
            end else if (next_step == IDLE) begin
                // Last micro-step ends: retire and reopen for the next instruction.
                state    <= IDLE;
                strb     <= '0;
                done     <= 1'b1;
                err      <= (op_q == OP_MOV) && (z_q == REG_AC);
                in_ready <= 1'b1;
`ifdef UC_RETIRE_CNT_EN
                retired  <= retired + 16'd1;
`endif
            end else begin
                state <= next_step;
                strb  <= decode(next_step, op_q, x_q, y_q, z_q);
            end
        end
    end

endmodule

// File: tb/tb_unidad_control.sv
// Self-checking bench for unidad_control: vector table, hand sequences and
// randomized instructions against an instruction-level register-file model.
module tb_unidad_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  instr;
    logic        in_ready, done, err;
    logic        Ra, Rb, Rc, Rac, Wa, Wb, Wc, Wac, Wt, S, R;
`ifdef UC_RETIRE_CNT_EN
    logic [15:0] retired;
`endif

    unidad_control dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .instr(instr),
        .in_ready(in_ready), .done(done), .err(err),
        .Ra(Ra), .Rb(Rb), .Rc(Rc), .Rac(Rac),
        .Wa(Wa), .Wb(Wb), .Wc(Wc), .Wac(Wac), .Wt(Wt), .S(S), .R(R)
`ifdef UC_RETIRE_CNT_EN
        , .retired(retired)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [10:0] RA = 11'h400, RB = 11'h200, RC = 11'h100, RAC = 11'h080;
    localparam logic [10:0] WA = 11'h040, WB = 11'h020, WC = 11'h010, WAC = 11'h008;
    localparam logic [10:0] WT = 11'h004, SS = 11'h002, RR = 11'h001;

    logic [10:0] strb;
    assign strb = {Ra, Rb, Rc, Rac, Wa, Wb, Wc, Wac, Wt, S, R};

    int checks = 0;
    int errors = 0;

    logic [7:0]  dp [4];   // datapath registers as driven by the DUT strobes
    logic [7:0]  dp_t;
    logic [7:0]  rf [4];   // instruction-level reference register file
    logic [10:0] exp_q [$];

    typedef struct {
        logic [7:0]  ins;
        int          n;
        logic        e;
        logic [10:0] first;
    } vec_t;
    vec_t vecs [9];

    function automatic logic [10:0] rd(input logic [1:0] c);
        case (c)
            2'd0: return RA;
            2'd1: return RB;
            2'd2: return RC;
            default: return RAC;
        endcase
    endfunction

    function automatic logic [10:0] wr(input logic [1:0] c);
        case (c)
            2'd0: return WA;
            2'd1: return WB;
            2'd2: return WC;
            default: return WAC;
        endcase
    endfunction

    // Expected micro-step strobe list for one instruction.
    function void model_steps(input logic [7:0] ins);
        logic [1:0] op, x, y, z;
        {op, x, y, z} = ins;
        exp_q.delete();
        if (op == 2'd0) begin
            exp_q.push_back((z == 2'd3) ? 11'h000 : (rd(x) | wr(z)));
        end else if (op == 2'd3) begin
            exp_q.push_back(WAC);
            if (z != 2'd3) exp_q.push_back(RAC | wr(z));
        end else begin
            exp_q.push_back(rd(y) | WT);
            exp_q.push_back(rd(x) | WAC | ((op == 2'd1) ? SS : RR));
            if (z != 2'd3) exp_q.push_back(RAC | wr(z));
        end
    endfunction

    // Architectural effect of one instruction (AC is the scratch result register).
    function void ref_exec(input logic [7:0] ins);
        logic [1:0] op, x, y, z;
        logic [7:0] res;
        {op, x, y, z} = ins;
        res = 8'd0;
        case (op)
            2'd0: if (z != 2'd3) rf[z] = rf[x];
            2'd1: begin res = rf[x] + rf[y]; rf[3] = res; rf[z] = res; end
            2'd2: begin res = rf[x] - rf[y]; rf[3] = res; rf[z] = res; end
            default: begin rf[3] = 8'd0; rf[z] = 8'd0; end
        endcase
    endfunction

    // Datapath stand-in plus the single-reader rule, evaluated every cycle.
    always @(negedge clk) begin : dp_model
        logic [7:0] bus, alu;
        int nr;
        nr = int'(Ra) + int'(Rb) + int'(Rc) + int'(Rac);
        checks++;
        if (nr > 1) begin
            errors++;
            $display("FAIL bus1_readers: got %0d readers, required at most 1 (t=%0t)", nr, $time);
        end
        bus = Ra ? dp[0] : Rb ? dp[1] : Rc ? dp[2] : Rac ? dp[3] : 8'd0;
        alu = S ? bus + dp_t : R ? bus - dp_t : 8'd0;
        if (Wt)  dp_t  = bus;
        if (Wac) dp[3] = alu;
        if (Wa)  dp[0] = bus;
        if (Wb)  dp[1] = bus;
        if (Wc)  dp[2] = bus;
    end

    task automatic check_regs(input string name);
        checks++;
        if ({dp[0], dp[1], dp[2], dp[3]} !== {rf[0], rf[1], rf[2], rf[3]}) begin
            errors++;
            $display("FAIL %s: regs A,B,C,AC got %h %h %h %h, required %h %h %h %h", name,
                     dp[0], dp[1], dp[2], dp[3], rf[0], rf[1], rf[2], rf[3]);
        end
    endtask

    // Issue one instruction from a negedge, observe its micro-steps until done.
    task automatic do_instr(input logic [7:0] ins, input bit junk, output int n_obs,
                            output logic [10:0] first_obs, output logic err_obs);
        logic [10:0] obs [$];
        int w, k;
        bit got, ok;
        w = 0;
        while (!in_ready && w < 20) begin @(negedge clk); w++; end
        n_obs = 0; first_obs = '0; err_obs = 1'b0;
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout: in_ready got 0, required 1 within 20 cycles");
            return;
        end
        in_valid = 1'b1;
        instr    = ins;
        @(posedge clk);
        #1 in_valid = 1'b0;
        instr = 8'($urandom);
        got = 1'b0; k = 0;
        while (!got && k < 8) begin
            @(negedge clk);
            if (done) got = 1'b1;
            else begin
                obs.push_back(strb);
                // Requests while busy must be ignored.
                if (junk && k == 0) begin in_valid = 1'b1; instr = 8'($urandom); end
            end
            k++;
        end
        in_valid = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout: instr %h got no done, required done within 8 cycles", ins);
        end
        n_obs     = obs.size();
        first_obs = (obs.size() > 0) ? obs[0] : 11'h000;
        err_obs   = err;
        model_steps(ins);
        ok = (obs.size() == exp_q.size());
        for (int i = 0; i < obs.size() && ok; i++) if (obs[i] !== exp_q[i]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL steps: instr %h got %0d steps first %h, required %0d steps first %h",
                     ins, obs.size(), first_obs, exp_q.size(), exp_q[0]);
        end
        checks++;
        if ({in_ready, err} !== {1'b1, (ins[7:6] == 2'd0 && ins[1:0] == 2'd3)}) begin
            errors++;
            $display("FAIL done_cycle: instr %h got in_ready=%b err=%b, required in_ready=1 err=%b",
                     ins, in_ready, err, (ins[7:6] == 2'd0 && ins[1:0] == 2'd3));
        end
        ref_exec(ins);
        check_regs("regs_after_instr");
    endtask

    initial begin
        int n, d1, d2;
        logic [10:0] f;
        logic e;
        bit saw;

        vecs[0] = '{8'h46, 3, 1'b0, RB | WT};
        vecs[1] = '{8'hA3, 2, 1'b0, RA | WT};
        vecs[2] = '{8'h02, 1, 1'b0, RA | WC};
        vecs[3] = '{8'h03, 1, 1'b1, 11'h000};
        vecs[4] = '{8'hC1, 2, 1'b0, WAC};
        vecs[5] = '{8'hC3, 1, 1'b0, WAC};
        vecs[6] = '{8'h7F, 2, 1'b0, RAC | WT};
        vecs[7] = '{8'h9B, 2, 1'b0, RC | WT};
        vecs[8] = '{8'h35, 1, 1'b0, RAC | WB};

        for (int i = 0; i < 4; i++) begin dp[i] = 8'($urandom); rf[i] = dp[i]; end
        dp_t = 8'd0;
        rst_n = 1'b0; in_valid = 1'b0; instr = 8'h00;

        // Reset held 3 cycles: everything low.
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({in_ready, done, err, strb} !== 14'd0) begin
                errors++;
                $display("FAIL reset_outputs: got %h, required 0", {in_ready, done, err, strb});
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b, required 1", in_ready);
        end

        // ADD A,B->C with A=B=10.
        dp[0] = 8'd10; dp[1] = 8'd10; rf[0] = 8'd10; rf[1] = 8'd10;
        do_instr(8'h46, 1'b0, n, f, e);
        checks++;
        if (dp[2] !== 8'd20) begin
            errors++; $display("FAIL add_result: C got %0d, required 20", dp[2]);
        end
        // SUB C,A->AC with C=A=10.
        dp[2] = 8'd10; dp[0] = 8'd10; rf[2] = 8'd10; rf[0] = 8'd10;
        do_instr(8'hA3, 1'b0, n, f, e);
        checks++;
        if (dp[3] !== 8'd0) begin
            errors++; $display("FAIL sub_result: AC got %0d, required 0", dp[3]);
        end

        foreach (vecs[i]) begin
            do_instr(vecs[i].ins, 1'b0, n, f, e);
            checks++;
            if (n != vecs[i].n || f !== vecs[i].first || e !== vecs[i].e) begin
                errors++;
                $display("FAIL vec_%0d: instr %h got n=%0d first=%h err=%b, required n=%0d first=%h err=%b",
                         i, vecs[i].ins, n, f, e, vecs[i].n, vecs[i].first, vecs[i].e);
            end
        end

        // Back-to-back: 0x46 then 0x02 with in_valid held.
        in_valid = 1'b1; instr = 8'h46;
        @(posedge clk);
        #1 instr = 8'h02;
        d1 = 0; d2 = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (done && d1 == 0) d1 = c;
            else if (done && d2 == 0) d2 = c;
            if (c == 5) in_valid = 1'b0;
        end
        checks++;
        if (d1 != 4) begin errors++; $display("FAIL b2b_first_done: cycle got %0d, required 4", d1); end
        checks++;
        if (d2 != 6) begin errors++; $display("FAIL b2b_second_done: cycle got %0d, required 6", d2); end
        ref_exec(8'h46); ref_exec(8'h02);
        check_regs("regs_after_b2b");

        // Reset during OPERA of an ADD: strobes drop at once, no done afterwards.
        in_valid = 1'b1; instr = 8'h46;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, done, err, strb} !== 14'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h, required 0", {in_ready, done, err, strb});
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (4) begin @(negedge clk); if (done) saw = 1'b1; end
        checks++;
        if (saw) begin errors++; $display("FAIL midreset_no_done: done got 1, required 0"); end
        for (int i = 0; i < 4; i++) rf[i] = dp[i];

        // Randomized instructions with idle gaps and ignored busy requests.
        repeat (40) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_instr(8'($urandom), 1'b1, n, f, e);
        end

`ifdef UC_RETIRE_CNT_EN
        @(negedge clk);
        force dut.retired = 16'hFFFF;
        #1 release dut.retired;
        do_instr(8'h02, 1'b0, n, f, e);
        checks++;
        if (retired !== 16'h0000) begin
            errors++; $display("FAIL retired_wrap: got %h, required 0000", retired);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
